// File: rtl/mko_pkg.sv
// Shared MKO (1895VA2T) definitions used by the register block and the host-port scheduler.
// Channel count, index width, bus field widths and the bus-cycle state encoding.
package mko_pkg;

    localparam int unsigned MKO_NCH    = 5;
    localparam int unsigned MKO_CH_W   = 3;
    localparam int unsigned MKO_ADDR_W = 12;
    localparam int unsigned MKO_DATA_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold,
        StDone,
        StErr
    } mko_state_e;

    // Active-low one-hot channel mask; out-of-range channels give all ones.
    function automatic logic [MKO_NCH-1:0] mko_sel_n(input logic [MKO_CH_W-1:0] ch);
        mko_sel_n = '1;
        for (int i = 0; i < int'(MKO_NCH); i++) begin
            if (ch == MKO_CH_W'(i)) begin
                mko_sel_n[i] = 1'b0;
            end
        end
    endfunction

endpackage

// File: rtl/mko_rr_arb.sv
// Round-robin priority encoder: combinational grant, registered pointer advanced
// to winner+1 when the scheduler finishes a transaction.
module mko_rr_arb #(
    parameter  int unsigned NREQ = 2,
    localparam int unsigned IW   = $clog2(NREQ)
) (
    input  logic            CLK_32,
    input  logic            RESET_N,
    input  logic [NREQ-1:0] req,
    input  logic            adv,
    input  logic [IW-1:0]   adv_idx,
    output logic [IW-1:0]   gnt_idx,
    output logic            gnt_vld
);

    logic [IW-1:0] ptr_q, ptr_d;
    int            j;

    // Scan from farthest to nearest so the requester closest to the pointer wins.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        j       = 0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            j = int'(ptr_q) + i;
            if (j >= int'(NREQ)) begin
                j = j - int'(NREQ);
            end
            if (req[IW'(j)]) begin
                gnt_idx = IW'(j);
                gnt_vld = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv) begin
            ptr_d = (adv_idx == IW'(NREQ - 1)) ? '0 : adv_idx + 1'b1;
        end
    end

    always_ff @(posedge CLK_32 or negedge RESET_N) begin
        if (!RESET_N) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mko_bus_sched.sv
// Shares the MKO parallel host port between NREQ local-bus requesters: round-robin grant,
// then one SELECT/RDWR/STRBD/READYD cycle on the target channel, finishing with ack or err.
module mko_bus_sched
    import mko_pkg::*;
#(
    parameter int unsigned NREQ      = 2,
    parameter int unsigned AW        = MKO_ADDR_W,
    parameter int unsigned DW        = MKO_DATA_W,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned HOLD_CYC  = 1,
    parameter int unsigned TMO_CYC   = 255
) (
    input  logic                   CLK_32,
    input  logic                   RESET_N,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        req_we,
    input  logic [3*NREQ-1:0]      req_dev,
    input  logic [AW*NREQ-1:0]     req_addr,
    input  logic [DW*NREQ-1:0]     req_wdata,
    output logic [NREQ-1:0]        ack,
    output logic [NREQ-1:0]        err,
    output logic [DW-1:0]          rdata,
    output logic                   busy,
    output logic [MKO_NCH-1:0]     MKO_SELECT_N,
    output logic [MKO_NCH-1:0]     MKO_STRBD_N,
    output logic                   MKO_RDWR_N,
    output logic [AW-1:0]          MKO_ADDR,
    output logic [DW-1:0]          MKO_DOUT,
    output logic                   MKO_DOE,
    input  logic [DW-1:0]          MKO_DIN,
    input  logic [MKO_NCH-1:0]     MKO_READYD_N
);

    localparam int unsigned IW = $clog2(NREQ);

    mko_state_e           state_q, state_d;
    logic [IW-1:0]        win_q, win_d, gnt_idx;
    logic                 gnt_vld, adv;
    logic                 we_q, we_d;
    logic [MKO_CH_W-1:0]  dev_q, dev_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [DW-1:0]        wdata_q, wdata_d;
    logic [DW-1:0]        rdata_q, rdata_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [MKO_NCH-1:0]   rdy_meta_q, rdy_sync_q;
    logic                 rdy_s;
    logic [MKO_NCH-1:0]   sel_n_q, sel_n_d, strb_n_q, strb_n_d;
    logic                 rdwr_n_q, rdwr_n_d, doe_q, doe_d;

    logic [MKO_CH_W-1:0]  dev_arr   [NREQ];
    logic [AW-1:0]        addr_arr  [NREQ];
    logic [DW-1:0]        wdata_arr [NREQ];

    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            dev_arr[i]   = req_dev[i*MKO_CH_W +: MKO_CH_W];
            addr_arr[i]  = req_addr[i*AW +: AW];
            wdata_arr[i] = req_wdata[i*DW +: DW];
        end
    end

    assign adv = (state_q == StDone) || (state_q == StErr);

    mko_rr_arb #(
        .NREQ(NREQ)
    ) u_arb (
        .CLK_32  (CLK_32),
        .RESET_N (RESET_N),
        .req     (req),
        .adv     (adv),
        .adv_idx (win_q),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign rdy_s = (dev_q < MKO_CH_W'(MKO_NCH)) ? rdy_sync_q[dev_q] : 1'b1;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        we_d    = we_q;
        dev_d   = dev_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (gnt_vld) begin
                    win_d = gnt_idx;
                    we_d  = req_we[gnt_idx];
                    dev_d = dev_arr[gnt_idx];
                    cnt_d = '0;
                    // A bad channel goes straight to ERR without touching the bus.
                    if (dev_arr[gnt_idx] >= MKO_CH_W'(MKO_NCH)) begin
                        state_d = StErr;
                    end else begin
                        addr_d  = addr_arr[gnt_idx];
                        wdata_d = wdata_arr[gnt_idx];
                        state_d = StSetup;
                    end
                end
            end
            StSetup: begin
                if (cnt_q == 8'(SETUP_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = StStrobe;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StStrobe: begin
                if (!rdy_s) begin
                    if (!we_q) begin
                        rdata_d = MKO_DIN;
                    end
                    cnt_d   = '0;
                    state_d = StHold;
                end else if (cnt_q == 8'(TMO_CYC - 1)) begin
                    state_d = StErr;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StHold: begin
                if (cnt_q == 8'(HOLD_CYC - 1)) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone, StErr: state_d = StIdle;
            default:       state_d = StIdle;
        endcase
    end

    // Pins are registered from the next state so they never glitch on a decode.
    always_comb begin
        sel_n_d  = '1;
        strb_n_d = '1;
        rdwr_n_d = 1'b1;
        doe_d    = 1'b0;
        if (state_d == StSetup || state_d == StStrobe || state_d == StHold) begin
            sel_n_d  = mko_sel_n(dev_d);
            rdwr_n_d = ~we_d;
            doe_d    = we_d;
        end
        if (state_d == StStrobe) begin
            strb_n_d = mko_sel_n(dev_d);
        end
    end

    always_ff @(posedge CLK_32 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= StIdle;
            win_q      <= '0;
            we_q       <= 1'b0;
            dev_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            cnt_q      <= '0;
            rdy_meta_q <= '1;
            rdy_sync_q <= '1;
            sel_n_q    <= '1;
            strb_n_q   <= '1;
            rdwr_n_q   <= 1'b1;
            doe_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            we_q       <= we_d;
            dev_q      <= dev_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            cnt_q      <= cnt_d;
            rdy_meta_q <= MKO_READYD_N;
            rdy_sync_q <= rdy_meta_q;
            sel_n_q    <= sel_n_d;
            strb_n_q   <= strb_n_d;
            rdwr_n_q   <= rdwr_n_d;
            doe_q      <= doe_d;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            ack[i] = (state_q == StDone) && (win_q == IW'(i));
            err[i] = (state_q == StErr) && (win_q == IW'(i));
        end
    end

    assign busy         = (state_q != StIdle);
    assign rdata        = rdata_q;
    assign MKO_SELECT_N = sel_n_q;
    assign MKO_STRBD_N  = strb_n_q;
    assign MKO_RDWR_N   = rdwr_n_q;
    assign MKO_DOE      = doe_q;
    assign MKO_ADDR     = addr_q;
    assign MKO_DOUT     = wdata_q;

endmodule

// File: doc/mko_bus_sched.md
Name: mko_bus_sched

Overview:
- Shares the single parallel host port of the five 1895VA2T MKO channel controllers between NREQ local-bus requesters.
- Requesters include the CPU register path and a DMA/telemetry engine.
- Round-robin arbitration per transaction, then sequences one complete SELECT/RDWR/STRBD/READYD bus cycle on the target channel and returns ack or error.
- Sits between the local-bus slave decode and the MKO pins, beside the existing MKO RDAT/reset register block.

Parameters:
- NREQ, 2, number of requesters (2..8)
- AW, 12, MKO register address width
- DW, 16, data width
- SETUP_CYC, 2, CLK_32 cycles SELECT_N low before STRBD_N falls (>=1)
- HOLD_CYC, 1, CLK_32 cycles SELECT_N held after STRBD_N rises (>=1)
- TMO_CYC, 255, maximum CLK_32 cycles in STROBE before timeout (8-bit counter)

Ports:
- CLK_32  in  1  system clock, 32 MHz
- RESET_N  in  1  reset, asynchronous, active-low
- req  in  NREQ  per-requester request, held until ack or err
- req_we  in  NREQ  1 = write, 0 = read
- req_dev  in  3*NREQ  packed target channel 0..4
- req_addr  in  AW*NREQ  packed MKO register address
- req_wdata  in  DW*NREQ  packed write data
- ack  out  NREQ  one-cycle completion pulse to the winner
- err  out  NREQ  one-cycle error pulse (bad channel or timeout)
- rdata  out  DW  read data, valid in the ack cycle, held until next read
- busy  out  1  high in any state except IDLE
- MKO_SELECT_N  out  5  per-channel select, active-low
- MKO_STRBD_N  out  5  per-channel strobe, active-low
- MKO_RDWR_N  out  1  0 = write, 1 = read
- MKO_ADDR  out  AW  shared address bus
- MKO_DOUT  out  DW  shared write data
- MKO_DOE  out  1  write-data output enable
- MKO_DIN  in  DW  shared read data
- MKO_READYD_N  in  5  per-channel ready, active-low, asynchronous

Behaviour:
- Reset (asynchronous, RESET_N low):
  - State IDLE; RR pointer = 0.
  - MKO_SELECT_N, MKO_STRBD_N = 5'b11111; MKO_RDWR_N = 1; MKO_DOE = 0.
  - MKO_ADDR, MKO_DOUT, rdata = 0; ack, err = 0; busy = 0.
  - Asserting reset mid-cycle releases all strobes/selects immediately; no ack or err for the aborted transfer.
- READYD_N synchronisation: 2-FF synchroniser per bit; only the winner channel's bit (rdy_s) is used.
- Arbitration:
  - In IDLE, the first requester at or after the pointer (cyclic) with req=1 wins.
  - Winner index, we, dev, addr and wdata are latched at that edge.
  - Pointer is updated to winner+1 (mod NREQ) on leaving DONE or ERR.
  - req changes after latching are ignored until IDLE.
- FSM:
  - IDLE -> SETUP when any req. If the latched dev > 4, go to ERR instead, with no pin activity.
  - SETUP:
    - SELECT_N[dev] = 0.
    - RDWR_N = ~we.
    - ADDR is driven.
    - If write: DOUT is driven and DOE = 1.
    - Runs SETUP_CYC cycles, then -> STROBE.
  - STROBE:
    - STRBD_N[dev] = 0; timeout counter increments from 0.
    - When rdy_s = 0: capture rdata <= MKO_DIN on reads (writes leave rdata unchanged), then -> HOLD.
    - When the counter reaches TMO_CYC first: -> ERR.
    - If rdy_s and the counter limit occur in the same cycle, ready wins.
  - HOLD: STRBD_N high, SELECT_N still low, DOE unchanged. Runs HOLD_CYC cycles, then -> DONE.
  - DONE: ack[winner] = 1 for one cycle; SELECT_N all high; DOE = 0; RDWR_N = 1 -> IDLE.
  - ERR: err[winner] = 1 for one cycle; all strobes/selects high; DOE = 0 -> IDLE.
- Only one channel's SELECT_N or STRBD_N is ever low. STRBD_N is never low while SELECT_N for the same channel is high.
- Back-to-back operation: IDLE lasts at least one cycle between transactions, so selects are high for at least one cycle.
- Latency with default parameters and READYD_N falling combinationally on strobe:
  - Req sampled at edge 0.
  - SETUP in cycles 1-2.
  - STROBE in cycles 3-5.
  - HOLD in cycle 6.
  - ack in cycle 7.

Decomposition:
- Shared package mko_pkg: MKO channel count (5), state encoding (IDLE, SETUP, STROBE, HOLD, DONE, ERR), channel-index width (3).
- The MKO channel count and the address-field constants are already used by the MKO register block; move them into mko_pkg.
- One sub-module: mko_rr_arb (NREQ-wide round-robin priority encoder with pointer register, combinational grant plus registered pointer).

Test Plan:
- Reset: hold RESET_N low mid-STROBE on channel 2 -> STRBD_N/SELECT_N = 11111 immediately; no ack/err; busy = 0.
- Single write: req0 with dev=3, addr=0x05A, wdata=0xBEEF; READYD_N[3] tied low during strobe:
  - SELECT_N = 10111 for cycles 1-6; STRBD_N = 10111 for cycles 3-5.
  - DOUT = 0xBEEF with DOE = 1; RDWR_N = 0.
  - ack[0] in cycle 7.
- Read: req1 with dev=0; MKO_DIN = 0x1234; READYD_N[0] low 4 cycles after strobe -> rdata = 0x1234 in the ack[1] cycle; RDWR_N = 1; DOE = 0 throughout.
- Round-robin: req0 and req1 held continuously, pointer = 0 -> grants alternate 0,1,0,1; at least one IDLE cycle with all selects high between transactions.
- Timeout: READYD_N[4] held high -> err pulse after TMO_CYC = 255 STROBE cycles; strobes released; next request is served normally.
- Bad channel: req with dev=6 -> err one cycle after IDLE sampling; no SELECT_N/STRBD_N activity.
